// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified-memory arbiter.
package mem_arb_pkg;

  // Owner of the read that is currently in flight (response phase).
  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_CORE = 2'd1,
    RSP_EXT  = 2'd2
  } rsp_state_e;

  // Width needed to hold 0..starve_max inclusive.
  function automatic int starve_w(input int starve_max);
    return $clog2(starve_max + 1);
  endfunction

  // 32-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating wait counter for the external port. Clear has priority over
// increment; at_max_o flags that the external port must win next.
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);

  localparam int            CW    = starve_w(STARVE_MAX);
  localparam logic [CW-1:0] MAX_V = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;

  // Next count: clear wins, otherwise increment until the ceiling.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clr_i) begin
      cnt_nxt_s = {CW{1'b0}};
    end else if (inc_i && (cnt_r != MAX_V)) begin
      cnt_nxt_s = cnt_r + CW'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign at_max_o = (cnt_r == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-ported unified memory.
// Core has fixed priority; the external port wins after STARVE_MAX lost
// cycles. Reads return one cycle after the grant.
// Optional build macro: MEM_ARB_STATS_EN adds grant/conflict counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            core_req_i,
  input  logic            core_we_i,
  input  logic [XLEN-1:0] core_addr_i,
  input  logic [XLEN-1:0] core_wdata_i,
  output logic            core_gnt_o,
  output logic            core_rvalid_o,
  output logic [XLEN-1:0] core_rdata_o,
  input  logic            ext_req_i,
  input  logic            ext_we_i,
  input  logic [XLEN-1:0] ext_addr_i,
  input  logic [XLEN-1:0] ext_wdata_i,
  output logic            ext_gnt_o,
  output logic            ext_rvalid_o,
  output logic [XLEN-1:0] ext_rdata_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]     core_grants_o,
  output logic [31:0]     ext_grants_o,
  output logic [31:0]     conflict_cnt_o
`endif
);

  logic            core_gnt_s;
  logic            ext_gnt_s;
  logic            ext_starved_s;
  logic            starve_clr_s;
  logic            starve_inc_s;
  rsp_state_e      state_r;
  rsp_state_e      state_nxt_s;
  logic [XLEN-1:0] core_rdata_r;
  logic [XLEN-1:0] ext_rdata_r;

  // Grant selection: starved external port, then core, then external.
  always_comb begin
    core_gnt_s = 1'b0;
    ext_gnt_s  = 1'b0;
    if (rst_i) begin
      core_gnt_s = 1'b0;
      ext_gnt_s  = 1'b0;
    end else if (ext_req_i && ext_starved_s) begin
      ext_gnt_s = 1'b1;
    end else if (core_req_i) begin
      core_gnt_s = 1'b1;
    end else if (ext_req_i) begin
      ext_gnt_s = 1'b1;
    end else begin
      core_gnt_s = 1'b0;
      ext_gnt_s  = 1'b0;
    end
  end

  assign core_gnt_o = core_gnt_s;
  assign ext_gnt_o  = ext_gnt_s;

  // Memory port follows the winner; idle port is driven to zero.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = {XLEN{1'b0}};
    mem_wdata_o = {XLEN{1'b0}};
    if (core_gnt_s) begin
      mem_we_o    = core_we_i;
      mem_addr_o  = core_addr_i;
      mem_wdata_o = core_wdata_i;
    end else if (ext_gnt_s) begin
      mem_we_o    = ext_we_i;
      mem_addr_o  = ext_addr_i;
      mem_wdata_o = ext_wdata_i;
    end else begin
      mem_we_o    = 1'b0;
      mem_addr_o  = {XLEN{1'b0}};
      mem_wdata_o = {XLEN{1'b0}};
    end
  end

  // A cycle lost to the core counts; a win or a dropped request restarts.
  assign starve_inc_s = ext_req_i && core_gnt_s;
  assign starve_clr_s = ext_gnt_s || !ext_req_i;

  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (starve_clr_s),
    .inc_i    (starve_inc_s),
    .at_max_o (ext_starved_s)
  );

  // Response FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= RSP_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Response FSM next state: only granted reads produce a response.
  always_comb begin
    state_nxt_s = RSP_IDLE;
    if (core_gnt_s && !core_we_i) begin
      state_nxt_s = RSP_CORE;
    end else if (ext_gnt_s && !ext_we_i) begin
      state_nxt_s = RSP_EXT;
    end else begin
      state_nxt_s = RSP_IDLE;
    end
  end

  // Response FSM outputs: one-cycle rvalid to the owner of the read.
  always_comb begin
    core_rvalid_o = 1'b0;
    ext_rvalid_o  = 1'b0;
    case (state_r)
      RSP_CORE: core_rvalid_o = 1'b1;
      RSP_EXT:  ext_rvalid_o  = 1'b1;
      default: begin
        core_rvalid_o = 1'b0;
        ext_rvalid_o  = 1'b0;
      end
    endcase
  end

  // Capture read data for the winner at the grant edge; hold otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      core_rdata_r <= {XLEN{1'b0}};
      ext_rdata_r  <= {XLEN{1'b0}};
    end else begin
      if (core_gnt_s && !core_we_i) begin
        core_rdata_r <= mem_rdata_i;
      end
      if (ext_gnt_s && !ext_we_i) begin
        ext_rdata_r <= mem_rdata_i;
      end
    end
  end

  assign core_rdata_o = core_rdata_r;
  assign ext_rdata_o  = ext_rdata_r;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] core_grants_r;
  logic [31:0] ext_grants_r;
  logic [31:0] conflict_cnt_r;

  // Saturating usage counters: grants per port and contended cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      core_grants_r  <= 32'd0;
      ext_grants_r   <= 32'd0;
      conflict_cnt_r <= 32'd0;
    end else begin
      if (core_gnt_s) begin
        core_grants_r <= sat_inc32(core_grants_r);
      end
      if (ext_gnt_s) begin
        ext_grants_r <= sat_inc32(ext_grants_r);
      end
      if (core_req_i && ext_req_i) begin
        conflict_cnt_r <= sat_inc32(conflict_cnt_r);
      end
    end
  end

  assign core_grants_o  = core_grants_r;
  assign ext_grants_o   = ext_grants_r;
  assign conflict_cnt_o = conflict_cnt_r;
`endif

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the multicycle core's single-ported unified instruction/data memory between the core (fetch, load, store) and an external port (program loader / debug). Each cycle it grants at most one requester, drives the memory port from the winner, and returns registered read data to the winner one cycle later. The core has fixed priority, and a starvation guard bounds the external port's wait. It sits between the core datapath's memory address/write-data path and the `memory` instance.

## Interface
- `XLEN`, 32, data and address width.
- `STARVE_MAX`, 8, consecutive lost cycles after which the external port wins; legal range 1..255.

Ports:
- `clk_i` in 1: clock; all state on the rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `core_req_i` in 1: core access request; held until granted.
- `core_we_i` in 1: core write (1) / read (0).
- `core_addr_i` in XLEN: core byte address.
- `core_wdata_i` in XLEN: core write data.
- `core_gnt_o` out 1: core access accepted this cycle.
- `core_rvalid_o` out 1: core read data valid.
- `core_rdata_o` out XLEN: core read data.
- `ext_req_i`, `ext_we_i`, `ext_addr_i`, `ext_wdata_i`, `ext_gnt_o`, `ext_rvalid_o`, `ext_rdata_o`: same as the core equivalents, for the external port.
- `mem_we_o` out 1: memory write enable.
- `mem_addr_o` out XLEN: memory address.
- `mem_wdata_o` out XLEN: memory write data.
- `mem_rdata_i` in XLEN: memory combinational read data for `mem_addr_o`.

## Operation
- **Arbitration (combinational, per cycle):**
  - If `ext_req_i` is high and `starve_cnt == STARVE_MAX`, grant the external port.
  - Otherwise, if `core_req_i` is high, grant the core.
  - Otherwise, if `ext_req_i` is high, grant the external port.
  - Otherwise, grant nobody.
- Exactly one of `core_gnt_o`/`ext_gnt_o` is high, or neither; both are forced to 0 while `rst_i` is high.
- **Memory port:**
  - `mem_addr_o`, `mem_wdata_o` and `mem_we_o` follow the winner.
  - `mem_we_o` is the winner's `we` ANDed with its grant.
  - With no grant: `mem_we_o` = 0 and `mem_addr_o`/`mem_wdata_o` = 0.
- **Starvation counter `starve_cnt`:**
  - Increments, saturating at `STARVE_MAX`, when `ext_req_i` is high and the core is granted.
  - Clears when `ext_gnt_o` is high or `ext_req_i` is low.
- **Response FSM** (state = owner of the in-flight read):
  - States: `RSP_IDLE`, `RSP_CORE`, `RSP_EXT`.
  - Next state is `RSP_CORE` on a granted core read, `RSP_EXT` on a granted external read, else `RSP_IDLE`. All transitions are possible every cycle.
  - Writes never produce a response.
- **Read data:**
  - `mem_rdata_i` is captured into the winner's rdata register at the grant edge.
  - `*_rvalid_o` is high for exactly one cycle, in the FSM state matching the port.
  - `*_rdata_o` holds its last captured value otherwise.
- **Reset mid-operation:** the in-flight response is dropped with no rvalid, the counter clears, and the FSM goes to `RSP_IDLE`.

## Timing
- Grant is same-cycle as the request (zero-cycle acceptance).
- Write commits at the rising edge ending the grant cycle.
- Read latency is 1: grant in cycle N, `rvalid`/`rdata` in cycle N+1.
- Back-to-back accesses are accepted every cycle. A response from cycle N coexists with a grant in N+1.
- The external port waits at most `STARVE_MAX` cycles under continuous core requests, then wins one cycle; the counter restarts from 0.
- Reset values: `starve_cnt` 0, FSM `RSP_IDLE`, both `rvalid` 0, both `rdata` 0, all grants 0, `mem_we_o` 0.

## Configuration
- Macro `MEM_ARB_STATS_EN`.
- **Defined:** adds outputs `core_grants_o`, `ext_grants_o` and `conflict_cnt_o`, each 32 bits, saturating at all-ones, reset to 0.
  - The grant counters count grants per port.
  - `conflict_cnt_o` counts cycles where both requests are high.
- **Undefined:** those ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `mem_arb_pkg` holds:
  - enum `rsp_state_e` (`RSP_IDLE`, `RSP_CORE`, `RSP_EXT`);
  - function `starve_w(STARVE_MAX)` returning the counter width `$clog2(STARVE_MAX+1)`.
- Sub-module `arb_starve_cnt`: a saturating counter with clear, increment and `at_max` outputs, parameterised by `STARVE_MAX`.
- Arbitration and the FSM stay in `mem_arbiter`.

## Test plan
- **Core-only read:** core read of 0x10 with the memory holding 0xDEADBEEF → `core_gnt_o` in cycle N, `core_rvalid_o` with 0xDEADBEEF in N+1, `ext_rvalid_o` stays 0.
- **Simultaneous requests:** core write 0x20←0x1 and external read 0x24 → core granted first. The external port is granted the next cycle, and its `rvalid` arrives one cycle after that.
- **Starvation (`STARVE_MAX`=3):** core requests continuously, external holds a read → core granted cycles 0–2, external granted in cycle 3, core granted again in cycle 4.
- **Back-to-back:** core reads 0x0, 0x4, 0x8 on consecutive cycles → three consecutive `rvalid` pulses with matching data, in order.
- **Reset mid-read:** assert `rst_i` in the cycle after a core read is granted → `core_rvalid_o` stays 0, all outputs go to their reset values, and the first post-reset request is granted normally.
- **Stats (`MEM_ARB_STATS_EN`):** after the simultaneous-request scenario → `core_grants_o`=1, `ext_grants_o`=1, `conflict_cnt_o`=1.
